// File: rtl/axi_lite_pkg.sv
// Shared types and constants for the AXI4-Lite control front-end.
//   resp_t      : AXI response codes used on BRESP/RRESP
//   wr_state_e  : write-path FSM states
//   rd_state_e  : read-path FSM states
//   RD_ERR_DATA : read data returned when a read access times out
package axi_lite_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } resp_t;

    typedef enum logic [1:0] {
        WIdle,
        WWait,
        WResp
    } wr_state_e;

    typedef enum logic [1:0] {
        RIdle,
        RWait,
        RResp
    } rd_state_e;

    localparam logic [31:0] RD_ERR_DATA = 32'hDEAD_BEEF;
    localparam logic [3:0]  STRB_FULL   = 4'hF;

endpackage

// File: rtl/axi_req_timer.sv
// Saturating access timer, one per direction.
//   clk, rst_n : clock and asynchronous active-low reset
//   clr        : zero the counter (takes priority over en)
//   en         : count this cycle (high while the owning FSM waits)
//   expired    : high on the TIMEOUT-th enabled cycle since the last clear
module axi_req_timer #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] CntMax  = CntW'(TIMEOUT);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    logic [CntW-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != CntMax)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The counter reads k-1 on the k-th waiting cycle, so this flags the cycle on
    // which the count reaches TIMEOUT.
    assign expired = en && (cnt_q >= CntLast);

endmodule

// File: rtl/axi_lite_ctrl.sv
// AXI4-Lite slave front-end that turns PS register accesses into held
// write/read requests for the PL address decoder, waits for the target's
// done strobe (with timeout) and returns the AXI response.
//   clk, rst_n              : clock, asynchronous active-low reset
//   s_axi_aw*/w*/b*         : AXI4-Lite write address/data/response channels
//   s_axi_ar*/r*            : AXI4-Lite read address/data channels
//   we, waddr, wdata, wdone : write request to decoder and its completion
//   re, raddr, rdone, rdata : read request to decoder, completion and data
// Write and read paths are independent and may be busy at the same time.
// Only DATA_W = 32 is supported (wstrb is fixed at 4 bits).
module axi_lite_ctrl
    import axi_lite_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] s_axi_awaddr,
    input  logic              s_axi_awvalid,
    output logic              s_axi_awready,
    input  logic [DATA_W-1:0] s_axi_wdata,
    input  logic [3:0]        s_axi_wstrb,
    input  logic              s_axi_wvalid,
    output logic              s_axi_wready,
    output logic [1:0]        s_axi_bresp,
    output logic              s_axi_bvalid,
    input  logic              s_axi_bready,
    input  logic [ADDR_W-1:0] s_axi_araddr,
    input  logic              s_axi_arvalid,
    output logic              s_axi_arready,
    output logic [DATA_W-1:0] s_axi_rdata,
    output logic [1:0]        s_axi_rresp,
    output logic              s_axi_rvalid,
    input  logic              s_axi_rready,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [DATA_W-1:0] wdata,
    input  logic              wdone,
    output logic              re,
    output logic [ADDR_W-1:0] raddr,
    input  logic              rdone,
    input  logic [DATA_W-1:0] rdata
);

    // ------------------------------------------------------------------
    // Write path
    // ------------------------------------------------------------------
    wr_state_e         wr_state_d, wr_state_q;
    logic              aw_got_d, aw_got_q;
    logic              w_got_d, w_got_q;
    logic              strb_ok_d, strb_ok_q;
    logic [ADDR_W-1:0] waddr_d, waddr_q;
    logic [DATA_W-1:0] wdata_d, wdata_q;
    resp_t             bresp_d, bresp_q;
    logic              awready_d, awready_q;
    logic              wready_d, wready_q;
    logic              bvalid_d, bvalid_q;
    logic              we_d, we_q;
    logic              wtmr_clr, wtmr_en, wtmr_expired;
    logic              aw_hs, w_hs;

    assign aw_hs = s_axi_awvalid && awready_q;
    assign w_hs  = s_axi_wvalid && wready_q;

    always_comb begin
        wr_state_d = wr_state_q;
        aw_got_d   = aw_got_q;
        w_got_d    = w_got_q;
        strb_ok_d  = strb_ok_q;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        bresp_d    = bresp_q;
        wtmr_clr   = 1'b0;

        unique case (wr_state_q)
            WIdle: begin
                if (aw_hs) begin
                    aw_got_d = 1'b1;
                    waddr_d  = s_axi_awaddr;
                end
                if (w_hs) begin
                    w_got_d   = 1'b1;
                    wdata_d   = s_axi_wdata;
                    strb_ok_d = (s_axi_wstrb == STRB_FULL);
                end
                if (aw_got_d && w_got_d) begin
                    if (strb_ok_d) begin
                        wr_state_d = WWait;
                        wtmr_clr   = 1'b1;
                    end else begin
                        // Partial writes are rejected without touching the target.
                        wr_state_d = WResp;
                        bresp_d    = SLVERR;
                    end
                end
            end
            WWait: begin
                // wdone wins over a simultaneous timeout.
                if (wdone) begin
                    wr_state_d = WResp;
                    bresp_d    = OKAY;
                end else if (wtmr_expired) begin
                    wr_state_d = WResp;
                    bresp_d    = SLVERR;
                end
            end
            WResp: begin
                if (s_axi_bready) begin
                    wr_state_d = WIdle;
                    aw_got_d   = 1'b0;
                    w_got_d    = 1'b0;
                end
            end
            default: begin
                wr_state_d = WIdle;
            end
        endcase

        // Handshake outputs are registered from the next state so that they
        // are all low while reset is held.
        awready_d = (wr_state_d == WIdle) && !aw_got_d;
        wready_d  = (wr_state_d == WIdle) && !w_got_d;
        bvalid_d  = (wr_state_d == WResp);
        we_d      = (wr_state_d == WWait);
    end

    assign wtmr_en = (wr_state_q == WWait);

    axi_req_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wr_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (wtmr_clr),
        .en      (wtmr_en),
        .expired (wtmr_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_state_q <= WIdle;
            aw_got_q   <= 1'b0;
            w_got_q    <= 1'b0;
            strb_ok_q  <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            bresp_q    <= OKAY;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            we_q       <= 1'b0;
        end else begin
            wr_state_q <= wr_state_d;
            aw_got_q   <= aw_got_d;
            w_got_q    <= w_got_d;
            strb_ok_q  <= strb_ok_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            bresp_q    <= bresp_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            bvalid_q   <= bvalid_d;
            we_q       <= we_d;
        end
    end

    assign s_axi_awready = awready_q;
    assign s_axi_wready  = wready_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = bresp_q;
    assign we            = we_q;
    assign waddr         = waddr_q;
    assign wdata         = wdata_q;

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    rd_state_e         rd_state_d, rd_state_q;
    logic [ADDR_W-1:0] raddr_d, raddr_q;
    logic [DATA_W-1:0] rdata_d, rdata_q;
    resp_t             rresp_d, rresp_q;
    logic              arready_d, arready_q;
    logic              rvalid_d, rvalid_q;
    logic              re_d, re_q;
    logic              rtmr_clr, rtmr_en, rtmr_expired;
    logic              ar_hs;

    assign ar_hs = s_axi_arvalid && arready_q;

    always_comb begin
        rd_state_d = rd_state_q;
        raddr_d    = raddr_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        rtmr_clr   = 1'b0;

        unique case (rd_state_q)
            RIdle: begin
                if (ar_hs) begin
                    rd_state_d = RWait;
                    raddr_d    = s_axi_araddr;
                    rtmr_clr   = 1'b1;
                end
            end
            RWait: begin
                if (rdone) begin
                    rd_state_d = RResp;
                    rdata_d    = rdata;
                    rresp_d    = OKAY;
                end else if (rtmr_expired) begin
                    rd_state_d = RResp;
                    rdata_d    = DATA_W'(RD_ERR_DATA);
                    rresp_d    = SLVERR;
                end
            end
            RResp: begin
                if (s_axi_rready) begin
                    rd_state_d = RIdle;
                end
            end
            default: begin
                rd_state_d = RIdle;
            end
        endcase

        arready_d = (rd_state_d == RIdle);
        rvalid_d  = (rd_state_d == RResp);
        re_d      = (rd_state_d == RWait);
    end

    assign rtmr_en = (rd_state_q == RWait);

    axi_req_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_rd_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (rtmr_clr),
        .en      (rtmr_en),
        .expired (rtmr_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_state_q <= RIdle;
            raddr_q    <= '0;
            rdata_q    <= '0;
            rresp_q    <= OKAY;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            re_q       <= 1'b0;
        end else begin
            rd_state_q <= rd_state_d;
            raddr_q    <= raddr_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            re_q       <= re_d;
        end
    end

    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rresp   = rresp_q;
    assign s_axi_rdata   = rdata_q;
    assign re            = re_q;
    assign raddr         = raddr_q;

endmodule

// File: tb/tb_axi_lite_ctrl.sv
// Directed testbench for axi_lite_ctrl with response scoreboards.
module tb_axi_lite_ctrl;
    import axi_lite_pkg::*;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] s_axi_awaddr = '0;
    logic          s_axi_awvalid = 1'b0;
    logic          s_axi_awready;
    logic [DW-1:0] s_axi_wdata = '0;
    logic [3:0]    s_axi_wstrb = 4'hF;
    logic          s_axi_wvalid = 1'b0;
    logic          s_axi_wready;
    logic [1:0]    s_axi_bresp;
    logic          s_axi_bvalid;
    logic          s_axi_bready = 1'b1;
    logic [AW-1:0] s_axi_araddr = '0;
    logic          s_axi_arvalid = 1'b0;
    logic          s_axi_arready;
    logic [DW-1:0] s_axi_rdata;
    logic [1:0]    s_axi_rresp;
    logic          s_axi_rvalid;
    logic          s_axi_rready = 1'b1;
    logic          we;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic          wdone = 1'b0;
    logic          re;
    logic [AW-1:0] raddr;
    logic          rdone = 1'b0;
    logic [DW-1:0] rdata = '0;

    always #5 clk = ~clk;

    axi_lite_ctrl #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .TIMEOUT (TO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready),
        .we            (we),
        .waddr         (waddr),
        .wdata         (wdata),
        .wdone         (wdone),
        .re            (re),
        .raddr         (raddr),
        .rdone         (rdone),
        .rdata         (rdata)
    );

    int total = 0;
    int bad = 0;
    int tick_n = 0;
    int we_cnt = 0;
    int re_cnt = 0;
    int wdone_at = 0;
    int rdone_at = 0;
    int b_seen = 0;
    int r_seen = 0;
    int aw_hs_at = -1;
    int w_hs_at = -1;
    int ar_hs_at = -1;
    int bv_at = -1;
    int rv_at = -1;
    logic [31:0] last_waddr = '0;
    logic [31:0] last_wdata = '0;
    logic [31:0] last_raddr = '0;
    logic [31:0] rd_val = '0;
    logic [1:0]  bq[$];
    logic [33:0] rq[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge. Handshakes are judged on the values
    // present at the current falling edge, i.e. those the next rising edge sees.
    task automatic tick();
        logic        aw_f, w_f, ar_f;
        logic [1:0]  eb;
        logic [33:0] er;
        aw_f = s_axi_awvalid && s_axi_awready;
        w_f  = s_axi_wvalid && s_axi_wready;
        ar_f = s_axi_arvalid && s_axi_arready;
        if (s_axi_bvalid && s_axi_bready) begin
            if (bq.size() == 0) begin
                check("b_stale", 64'(s_axi_bvalid), 64'd0);
            end else begin
                eb = bq.pop_front();
                check("bresp", 64'(s_axi_bresp), 64'(eb));
                b_seen++;
            end
        end
        if (s_axi_rvalid && s_axi_rready) begin
            if (rq.size() == 0) begin
                check("r_stale", 64'(s_axi_rvalid), 64'd0);
            end else begin
                er = rq.pop_front();
                check("rresp", 64'(s_axi_rresp), 64'(er[33:32]));
                check("rdata", 64'(s_axi_rdata), 64'(er[31:0]));
                r_seen++;
            end
        end
        @(negedge clk);
        tick_n++;
        if (aw_f) begin s_axi_awvalid = 1'b0; aw_hs_at = tick_n - 1; end
        if (w_f)  begin s_axi_wvalid  = 1'b0; w_hs_at  = tick_n - 1; end
        if (ar_f) begin s_axi_arvalid = 1'b0; ar_hs_at = tick_n - 1; end
        if (we) begin we_cnt++; last_waddr = waddr; last_wdata = wdata; end
        if (re) begin re_cnt++; last_raddr = raddr; end
        wdone = we && (wdone_at != 0) && (we_cnt == wdone_at);
        rdone = re && (rdone_at != 0) && (re_cnt == rdone_at);
        rdata = rdone ? rd_val : 32'h0;
        if (s_axi_bvalid && bv_at < 0) bv_at = tick_n;
        if (s_axi_rvalid && rv_at < 0) rv_at = tick_n;
    endtask

    task automatic do_write(input string tag, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int w_lead, input int done_at,
                            input logic [1:0] exp_resp, input int exp_we, input int exp_lat);
        int b0;
        int hs;
        b0 = b_seen;
        bq.push_back(exp_resp);
        we_cnt = 0; wdone_at = done_at; bv_at = -1; aw_hs_at = -1; w_hs_at = -1;
        s_axi_wdata = data; s_axi_wstrb = strb; s_axi_awaddr = addr; s_axi_wvalid = 1'b1;
        if (w_lead == 0) begin
            s_axi_awvalid = 1'b1;
        end else begin
            repeat (w_lead) tick();
            check({tag, "_no_we_before_aw"}, 64'(we_cnt), 64'd0);
            s_axi_awvalid = 1'b1;
        end
        for (int i = 0; i < 100 && b_seen == b0; i++) tick();
        check({tag, "_b_done"}, 64'(b_seen), 64'(b0 + 1));
        check({tag, "_we_cycles"}, 64'(we_cnt), 64'(exp_we));
        if (exp_we > 0) begin
            check({tag, "_waddr"}, 64'(last_waddr), 64'(addr));
            check({tag, "_wdata"}, 64'(last_wdata), 64'(data));
        end
        if (exp_lat > 0) begin
            hs = (aw_hs_at > w_hs_at) ? aw_hs_at : w_hs_at;
            check({tag, "_b_latency"}, 64'(bv_at - hs), 64'(exp_lat));
        end
        wdone_at = 0;
        tick();
    endtask

    task automatic do_read(input string tag, input logic [31:0] addr, input int done_at,
                           input logic [31:0] rd, input int delay, input logic [1:0] exp_resp,
                           input logic [31:0] exp_data, input int exp_re, input int exp_lat);
        int r0;
        int stall;
        r0 = r_seen;
        rq.push_back({exp_resp, exp_data});
        re_cnt = 0; rdone_at = done_at; rd_val = rd; rv_at = -1; ar_hs_at = -1; stall = 0;
        s_axi_araddr = addr; s_axi_arvalid = 1'b1; s_axi_rready = (delay == 0);
        for (int i = 0; i < 100 && r_seen == r0; i++) begin
            tick();
            if (s_axi_rvalid && !s_axi_rready) begin
                stall++;
                check({tag, "_hold_rdata"}, 64'(s_axi_rdata), 64'(exp_data));
                check({tag, "_hold_rresp"}, 64'(s_axi_rresp), 64'(exp_resp));
                if (stall >= delay) s_axi_rready = 1'b1;
            end
        end
        check({tag, "_r_done"}, 64'(r_seen), 64'(r0 + 1));
        check({tag, "_re_cycles"}, 64'(re_cnt), 64'(exp_re));
        if (exp_re > 0) check({tag, "_raddr"}, 64'(last_raddr), 64'(addr));
        if (delay > 0) check({tag, "_stall_cycles"}, 64'(stall), 64'(delay));
        if (exp_lat > 0) check({tag, "_r_latency"}, 64'(rv_at - ar_hs_at), 64'(exp_lat));
        rdone_at = 0;
        s_axi_rready = 1'b1;
        tick();
    endtask

    initial begin
        int b0;
        int r0;

        // Reset state
        repeat (3) tick();
        check("rst_awready", 64'(s_axi_awready), 64'd0);
        check("rst_wready", 64'(s_axi_wready), 64'd0);
        check("rst_arready", 64'(s_axi_arready), 64'd0);
        check("rst_bvalid", 64'(s_axi_bvalid), 64'd0);
        check("rst_rvalid", 64'(s_axi_rvalid), 64'd0);
        check("rst_we", 64'(we), 64'd0);
        check("rst_re", 64'(re), 64'd0);
        check("rst_bresp", 64'(s_axi_bresp), 64'd0);
        check("rst_rresp", 64'(s_axi_rresp), 64'd0);
        check("rst_waddr", 64'(waddr), 64'd0);
        check("rst_wdata", 64'(wdata), 64'd0);
        check("rst_raddr", 64'(raddr), 64'd0);
        check("rst_rdata", 64'(s_axi_rdata), 64'd0);
        rst_n = 1'b1;
        repeat (2) tick();
        check("idle_awready", 64'(s_axi_awready), 64'd1);
        check("idle_arready", 64'(s_axi_arready), 64'd1);

        // Writes
        do_write("wr_same", 32'h0000_0010, 32'hA5A5_0001, 4'hF, 0, 1, OKAY, 1, 2);
        do_write("wr_wfirst", 32'h8000_0040, 32'h0BAD_F00D, 4'hF, 3, 1, OKAY, 1, 0);
        do_write("wr_strb", 32'h0000_0020, 32'h1111_2222, 4'h3, 0, 1, SLVERR, 0, 0);
        do_write("wr_to", 32'h0000_0030, 32'h3333_4444, 4'hF, 0, 0, SLVERR, TO, 0);
        do_write("wr_to_late", 32'h0000_0034, 32'h5555_6666, 4'hF, 0, TO, OKAY, TO, 0);

        // Reads
        do_read("rd_ok", 32'h0000_0004, 1, 32'h1234_5678, 5, OKAY, 32'h1234_5678, 1, 2);
        do_read("rd_to", 32'h0000_0008, 0, 32'h0, 0, SLVERR, RD_ERR_DATA, TO, 0);

        // Concurrent write and read, both complete
        b0 = b_seen; r0 = r_seen;
        bq.push_back(OKAY);
        rq.push_back({OKAY, 32'hCAFE_0002});
        we_cnt = 0; re_cnt = 0; wdone_at = 3; rdone_at = 2; rd_val = 32'hCAFE_0002;
        s_axi_awaddr = 32'h0000_0100; s_axi_wdata = 32'h7777_8888; s_axi_wstrb = 4'hF;
        s_axi_araddr = 32'h0000_0200;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_arvalid = 1'b1;
        for (int i = 0; i < 100 && (b_seen == b0 || r_seen == r0); i++) tick();
        check("conc_b_done", 64'(b_seen), 64'(b0 + 1));
        check("conc_r_done", 64'(r_seen), 64'(r0 + 1));
        check("conc_we_cycles", 64'(we_cnt), 64'd3);
        check("conc_re_cycles", 64'(re_cnt), 64'd2);
        wdone_at = 0; rdone_at = 0;
        tick();

        // Concurrent accesses aborted by reset while waiting
        b0 = b_seen; r0 = r_seen;
        we_cnt = 0; re_cnt = 0;
        s_axi_awaddr = 32'h0000_0300; s_axi_wdata = 32'h9999_AAAA; s_axi_araddr = 32'h0000_0400;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_arvalid = 1'b1;
        for (int i = 0; i < 10 && !(we && re); i++) tick();
        repeat (2) tick();
        check("abort_pre_we", 64'(we), 64'd1);
        check("abort_pre_re", 64'(re), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_we", 64'(we), 64'd0);
        check("abort_re", 64'(re), 64'd0);
        check("abort_bvalid", 64'(s_axi_bvalid), 64'd0);
        check("abort_rvalid", 64'(s_axi_rvalid), 64'd0);
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (20) tick();
        check("abort_no_b", 64'(b_seen), 64'(b0));
        check("abort_no_r", 64'(r_seen), 64'(r0));

        // Recovery after reset
        do_write("wr_after_rst", 32'h0000_0044, 32'h0F0F_0F0F, 4'hF, 0, 2, OKAY, 2, 0);
        do_read("rd_after_rst", 32'h0000_0048, 1, 32'hFACE_B00C, 0, OKAY, 32'hFACE_B00C, 1, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
